// File: rtl/ob_pkg.sv
// Order-book shared types and the libv flop macros (synchronous, active-high reset).
// Conditional-table sizing lives here so the table and its controller agree.
`ifndef LIBV_REGS_DEFINED
`define LIBV_REGS_DEFINED
`define LIBV_REG_RST(clk, rst, q, d, rv) always_ff @(posedge clk) if (rst) q <= (rv); else q <= (d);
`define LIBV_REG_EN_RST(clk, rst, en, q, d, rv) always_ff @(posedge clk) if (rst) q <= (rv); else if (en) q <= (d);
`endif

package ob_pkg;

   typedef enum logic [1:0] {
      OP_LIMIT      = 2'd0,
      OP_MARKET     = 2'd1,
      OP_STOP       = 2'd2,
      OP_STOP_LIMIT = 2'd3
   } op_t;

   typedef struct packed {
      op_t         op;
      logic        side;
      logic [15:0] oid;
      logic [23:0] px;
      logic [15:0] qty;
   } cmd_t;

   localparam int CN_N = 16;
   typedef logic [$clog2(CN_N)-1:0] cn_ptr_t;

endpackage

// File: rtl/ob_cn_rr_arb.sv
// N-way round-robin arbiter: first request at or after ptr wins, searching upward and wrapping.
// Purely combinational; one-hot grant plus encoded index and an any-request flag.
module ob_cn_rr_arb #(
   parameter int N = 16
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int PW = $clog2(N);

   logic [PW-1:0] k;

   // N is a power of two, so the pointer sum wraps N-1 -> 0 by itself.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = '0;
      for (int i = 0; i < N; i++) begin
         k = ptr + PW'(i);
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/ob_cn_table_ctrl.sv
// Conditional-order table control: lowest-free allocation (combinational), round-robin issue
// of matured entries into a one-deep output register; matured entries wait in the table under backpressure.
module ob_cn_table_ctrl
   import ob_pkg::*;
#(
   parameter int N = CN_N
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_vld,
   input  cmd_t                   in_cmd,
   output logic                   in_rdy,
   output logic [N-1:0]           ent_al_vld,
   output cmd_t                   ent_al_cmd,
   input  logic [N-1:0]           ent_busy_r,
   input  logic [N-1:0]           ent_mtr_r,
   input  cmd_t [N-1:0]           ent_cmd_r,
   input  logic [N-1:0]           ent_cancel_hit,
   output logic [N-1:0]           ent_dl_vld,
   output logic                   out_vld,
   output cmd_t                   out_cmd,
   input  logic                   out_rdy,
   output logic [$clog2(N+1)-1:0] occ_r,
   output logic                   full_r
);

   localparam int PW = $clog2(N);
   localparam int OW = $clog2(N+1);

   logic [N-1:0]  free;
   logic [N-1:0]  al_gnt;
   logic [N-1:0]  elig;
   logic [N-1:0]  arb_gnt;
   logic [PW-1:0] sel;
   logic [PW-1:0] rr_r;
   logic [PW-1:0] rr_nxt;
   logic          arb_any;
   logic          ld;
   logic          out_vld_nxt;
   logic          alloc_eff;
   logic [OW-1:0] cnc;
   logic [OW-1:0] occ_nxt;

   // Lowest set bit of the free vector.
   assign free       = ~ent_busy_r;
   assign al_gnt     = free & (~free + N'(1));
   assign in_rdy     = |free;
   assign ent_al_vld = in_vld ? al_gnt : '0;
   assign ent_al_cmd = in_cmd;

   // A cancel landing on a matured entry wins; that entry must never be issued.
   assign elig = ent_mtr_r & ~ent_cancel_hit;

   ob_cn_rr_arb #(.N(N)) u_arb (
      .req (elig),
      .ptr (rr_r),
      .gnt (arb_gnt),
      .idx (sel),
      .any (arb_any)
   );

   assign ld          = arb_any & (~out_vld | out_rdy);
   assign ent_dl_vld  = ld ? arb_gnt : '0;
   assign out_vld_nxt = ld | (out_vld & ~out_rdy);
   assign rr_nxt      = sel + PW'(1);

   // An allocate whose target is cancelled in the same cycle leaves the entry idle.
   assign alloc_eff = |(ent_al_vld & ~ent_cancel_hit);
   assign cnc       = OW'($countones(ent_cancel_hit & ent_busy_r));
   assign occ_nxt   = occ_r + OW'(alloc_eff) - OW'(ld) - cnc;

   `LIBV_REG_RST(clk, rst, out_vld, out_vld_nxt, 1'b0)
   `LIBV_REG_EN_RST(clk, rst, ld, out_cmd, ent_cmd_r[sel], '0)
   `LIBV_REG_EN_RST(clk, rst, ld, rr_r, rr_nxt, '0)
   `LIBV_REG_RST(clk, rst, occ_r, occ_nxt, '0)
   `LIBV_REG_RST(clk, rst, full_r, (occ_nxt == OW'(N)), 1'b0)

   occ_matches_busy: assert property (@(posedge clk) disable iff (rst)
      occ_r == OW'($countones(ent_busy_r)));

endmodule

// File: tb/tb_ob_cn_table_ctrl.sv
// Bench for ob_cn_table_ctrl: entry-array stand-in, table vectors, directed corner sequences, random run vs model.
module tb_ob_cn_table_ctrl;
   import ob_pkg::*;

   localparam int N  = CN_N;
   localparam int OW = $clog2(N+1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1;
   logic           in_vld = 1'b0;
   cmd_t           in_cmd = '0;
   logic           in_rdy;
   logic [N-1:0]   ent_al_vld;
   cmd_t           ent_al_cmd;
   logic [N-1:0]   ent_busy_r;
   logic [N-1:0]   ent_mtr_r;
   cmd_t [N-1:0]   ent_cmd_r;
   logic [N-1:0]   ent_cancel_hit = '0;
   logic [N-1:0]   ent_dl_vld;
   logic           out_vld;
   cmd_t           out_cmd;
   logic           out_rdy = 1'b1;
   logic [OW-1:0]  occ_r;
   logic           full_r;

   ob_cn_table_ctrl #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy),
      .ent_al_vld(ent_al_vld), .ent_al_cmd(ent_al_cmd), .ent_busy_r(ent_busy_r),
      .ent_mtr_r(ent_mtr_r), .ent_cmd_r(ent_cmd_r), .ent_cancel_hit(ent_cancel_hit),
      .ent_dl_vld(ent_dl_vld), .out_vld(out_vld), .out_cmd(out_cmd), .out_rdy(out_rdy),
      .occ_r(occ_r), .full_r(full_r)
   );

   int n_vec = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   function automatic cmd_t rewrite(input cmd_t c);
      cmd_t r = c;
      if (c.op == OP_STOP) r.op = OP_MARKET;
      else if (c.op == OP_STOP_LIMIT) r.op = OP_LIMIT;
      return r;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic cmd_t rand_cmd();
      logic [63:0] r = {$urandom, $urandom};
      return r[$bits(cmd_t)-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Stand-in for the entry array: entries hold their command, mature on request, clear on dl/cancel.
   logic         tbl_mode = 1'b1;
   logic [N-1:0] tbl_busy = '0, tbl_mtr = '0;
   logic [N-1:0] e_busy, e_mtr;
   logic [N-1:0] mat_req = '0;
   cmd_t         e_cmd [N];

   assign ent_busy_r = tbl_mode ? tbl_busy : e_busy;
   assign ent_mtr_r  = tbl_mode ? tbl_mtr  : e_mtr;

   always_comb begin
      ent_cmd_r = '0;
      for (int i = 0; i < N; i++) ent_cmd_r[i] = rewrite(e_cmd[i]);
   end

   always @(posedge clk) begin
      if (rst) begin
         e_busy <= '0;
         e_mtr  <= '0;
         for (int i = 0; i < N; i++) e_cmd[i] <= '0;
      end else if (!tbl_mode) begin
         for (int i = 0; i < N; i++) begin
            if (ent_dl_vld[i] || ent_cancel_hit[i]) begin
               e_busy[i] <= 1'b0;
               e_mtr[i]  <= 1'b0;
            end else if (ent_al_vld[i]) begin
               e_busy[i] <= 1'b1;
               e_cmd[i]  <= in_cmd;
            end else if (mat_req[i] && e_busy[i]) begin
               e_mtr[i] <= 1'b1;
            end
         end
      end
   end

   // Reference model: output slot, rotating search start, occupied count.
   logic m_vld, n_vld;
   cmd_t m_cmd, n_cmd;
   int   m_rr, n_rr, m_occ, n_occ;

   task automatic model_eval();
      int first = -1;
      int sel = -1;
      int cnc = 0;
      int k;
      logic [N-1:0] x_al = '0, x_dl = '0, elig;
      logic load, alloc_eff;
      for (int i = 0; i < N; i++) if (!ent_busy_r[i] && first < 0) first = i;
      if (in_vld && first >= 0) x_al[first] = 1'b1;
      elig = ent_mtr_r & ~ent_cancel_hit;
      for (int i = 0; i < N; i++) begin
         k = (m_rr + i) % N;
         if (sel < 0 && elig[k]) sel = k;
      end
      load = (sel >= 0) && (!m_vld || out_rdy);
      if (load) x_dl[sel] = 1'b1;
      for (int i = 0; i < N; i++) if (ent_cancel_hit[i] && ent_busy_r[i]) cnc++;
      alloc_eff = (x_al != '0) && ((x_al & ent_cancel_hit) == '0);
      n_vld = load ? 1'b1 : (m_vld && !out_rdy);
      n_cmd = m_cmd;
      n_rr  = m_rr;
      if (load) begin
         n_cmd = ent_cmd_r[sel];
         n_rr  = (sel + 1) % N;
      end
      n_occ = m_occ + (alloc_eff ? 1 : 0) - (load ? 1 : 0) - cnc;
      if (chk_en) begin
         chk("in_rdy", 64'(in_rdy), 64'(first >= 0));
         chk("al_vld", 64'(ent_al_vld), 64'(x_al));
         chk("al_cmd", 64'(ent_al_cmd), 64'(in_cmd));
         chk("dl_vld", 64'(ent_dl_vld), 64'(x_dl));
         chk("out_vld", 64'(out_vld), 64'(m_vld));
         if (m_vld) chk("out_cmd", 64'(out_cmd), 64'(m_cmd));
         chk("occ", 64'(occ_r), 64'(m_occ));
         chk("full", 64'(full_r), 64'(m_occ == N));
      end
   endtask

   task automatic model_commit();
      if (rst) begin
         m_vld = 1'b0; m_cmd = '0; m_rr = 0; m_occ = 0;
      end else begin
         m_vld = n_vld; m_cmd = n_cmd; m_rr = n_rr; m_occ = n_occ;
      end
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic adv();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic step();
      settle();
      adv();
   endtask

   typedef struct {
      logic         v;
      logic [N-1:0] busy, mtr, cnc;
      logic         x_rdy;
      logic [N-1:0] x_al, x_dl;
   } tv_t;
   tv_t tv [10];

   cmd_t sent [N];
   int   seq_b  [3] = '{3, 7, 12};
   int   refill [6] = '{3, 4, 5, 7, 9, 12};

   initial begin
      tv[0] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
      tv[1] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0001, 16'h0000};
      tv[2] = '{1'b1, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 16'h0100, 16'h0000};
      tv[3] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
      tv[4] = '{1'b1, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h0000};
      tv[5] = '{1'b0, 16'hFFFF, 16'h1010, 16'h0000, 1'b0, 16'h0000, 16'h0010};
      tv[6] = '{1'b0, 16'hFFFF, 16'h1010, 16'h0010, 1'b0, 16'h0000, 16'h1000};
      tv[7] = '{1'b0, 16'hFFFF, 16'h0010, 16'h0010, 1'b0, 16'h0000, 16'h0000};
      tv[8] = '{1'b1, 16'hFFFE, 16'h8000, 16'h0001, 1'b1, 16'h0001, 16'h8000};
      tv[9] = '{1'b0, 16'hAAAA, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};

      // Combinational paths under reset (output register empty, pointer at 0).
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         in_vld = tv[i].v; tbl_busy = tv[i].busy; tbl_mtr = tv[i].mtr; ent_cancel_hit = tv[i].cnc;
         @(negedge clk);
         chk("tbl_in_rdy", 64'(in_rdy), 64'(tv[i].x_rdy));
         chk("tbl_al_vld", 64'(ent_al_vld), 64'(tv[i].x_al));
         chk("tbl_dl_vld", 64'(ent_dl_vld), 64'(tv[i].x_dl));
         @(posedge clk); #1;
      end
      in_vld = 1'b0; ent_cancel_hit = '0; tbl_mode = 1'b0;
      step(); step();
      rst = 1'b0; chk_en = 1'b1;
      settle();
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_out_cmd", 64'(out_cmd), 64'd0);
      chk("rst_occ", 64'(occ_r), 64'd0);
      chk("rst_full", 64'(full_r), 64'd0);
      adv();

      // Fill all entries back to back.
      in_vld = 1'b1; out_rdy = 1'b1;
      for (int i = 0; i < N; i++) begin
         in_cmd = rand_cmd(); sent[i] = in_cmd;
         settle(); chk("fill_al", 64'(ent_al_vld), 64'(onehot(i))); adv();
      end
      in_cmd = rand_cmd();
      settle();
      chk("full_in_rdy", 64'(in_rdy), 64'd0);
      chk("full_al", 64'(ent_al_vld), 64'd0);
      chk("full_occ", 64'(occ_r), 64'(N));
      chk("full_flag", 64'(full_r), 64'd1);
      adv();
      in_vld = 1'b0;

      // Three entries mature together: issued in index order on consecutive cycles.
      mat_req = onehot(3) | onehot(7) | onehot(12); step(); mat_req = '0;
      for (int j = 0; j < 3; j++) begin
         settle();
         chk("rr3_dl", 64'(ent_dl_vld), 64'(onehot(seq_b[j])));
         chk("rr3_occ", 64'(occ_r), 64'(N - j));
         if (j > 0) chk("rr3_cmd", 64'(out_cmd), 64'(rewrite(sent[seq_b[j-1]])));
         adv();
      end
      settle();
      chk("rr3_occ_end", 64'(occ_r), 64'(N - 3));
      chk("rr3_cmd_end", 64'(out_cmd), 64'(rewrite(sent[12])));
      adv();

      // Backpressure: 5 issues, 9 waits in the table until out_rdy returns.
      out_rdy = 1'b0; mat_req = onehot(5) | onehot(9); step(); mat_req = '0;
      settle(); chk("bp_dl5", 64'(ent_dl_vld), 64'(onehot(5))); adv();
      for (int j = 0; j < 4; j++) begin
         settle();
         chk("bp_vld", 64'(out_vld), 64'd1);
         chk("bp_cmd", 64'(out_cmd), 64'(rewrite(sent[5])));
         chk("bp_no_dl", 64'(ent_dl_vld), 64'd0);
         adv();
      end
      out_rdy = 1'b1;
      settle(); chk("bp_dl9", 64'(ent_dl_vld), 64'(onehot(9))); adv();
      settle();
      chk("bp_cmd9", 64'(out_cmd), 64'(rewrite(sent[9])));
      chk("bp_occ", 64'(occ_r), 64'd11);
      adv();

      // Matured entry cancelled in the same cycle.
      mat_req = onehot(4); step(); mat_req = '0; ent_cancel_hit = onehot(4);
      settle();
      chk("cnc_no_dl", 64'(ent_dl_vld), 64'd0);
      chk("cnc_occ0", 64'(occ_r), 64'd11);
      adv();
      ent_cancel_hit = '0;
      settle();
      chk("cnc_no_vld", 64'(out_vld), 64'd0);
      chk("cnc_occ1", 64'(occ_r), 64'd10);
      adv();

      // Refill, then free entry 0 while a command is waiting.
      in_vld = 1'b1;
      for (int j = 0; j < 6; j++) begin
         in_cmd = rand_cmd(); sent[refill[j]] = in_cmd;
         settle(); chk("refill_al", 64'(ent_al_vld), 64'(onehot(refill[j]))); adv();
      end
      in_cmd = rand_cmd(); mat_req = onehot(0); step(); mat_req = '0;
      settle();
      chk("free0_in_rdy", 64'(in_rdy), 64'd0);
      chk("free0_dl", 64'(ent_dl_vld), 64'(onehot(0)));
      chk("free0_occ", 64'(occ_r), 64'(N));
      adv();
      sent[0] = in_cmd;
      settle();
      chk("free0_al", 64'(ent_al_vld), 64'(onehot(0)));
      chk("free0_occ1", 64'(occ_r), 64'(N - 1));
      adv();
      in_vld = 1'b0;
      settle(); chk("free0_occ2", 64'(occ_r), 64'(N)); chk("free0_full", 64'(full_r), 64'd1); adv();

      // Pointer wrap: issue 14 so the search starts at 15, then 15 and 0 together.
      mat_req = onehot(14); step(); mat_req = onehot(15) | onehot(0);
      settle(); chk("wrap_dl14", 64'(ent_dl_vld), 64'(onehot(14))); adv();
      mat_req = '0;
      settle(); chk("wrap_dl15", 64'(ent_dl_vld), 64'(onehot(15))); adv();
      settle();
      chk("wrap_dl0", 64'(ent_dl_vld), 64'(onehot(0)));
      chk("wrap_cmd15", 64'(out_cmd), 64'(rewrite(sent[15])));
      adv();
      settle(); chk("wrap_cmd0", 64'(out_cmd), 64'(rewrite(sent[0]))); adv();

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         in_vld  = ($urandom_range(0, 3) != 0);
         in_cmd  = rand_cmd();
         out_rdy = ($urandom_range(0, 3) != 0);
         mat_req = N'($urandom) & N'($urandom);
         ent_cancel_hit = '0;
         if ($urandom_range(0, 5) == 0) ent_cancel_hit[$urandom_range(0, N-1)] = 1'b1;
         step();
      end

      // Reset mid-operation.
      in_vld = 1'b0; mat_req = '0; ent_cancel_hit = '0; out_rdy = 1'b0;
      rst = 1'b1; step(); rst = 1'b0;
      settle();
      chk("mid_rst_vld", 64'(out_vld), 64'd0);
      chk("mid_rst_occ", 64'(occ_r), 64'd0);
      chk("mid_rst_full", 64'(full_r), 64'd0);
      adv();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ob_cn_table_ctrl.md
# ob_cn_table_ctrl

Control block for the conditional-order (stop-loss / stop-limit) table. It handles both ends of each table entry's life:
- Front end: accepts new conditional commands, finds a free entry and pulses that entry's allocate strobe.
- Back end: watches the matured flags, picks one matured entry round-robin, moves its rewritten command into an output register for the order pipeline, and pulses that entry's deallocate strobe.

It sits between the order-book command dispatcher and the array of conditional-table entries.

## Interface
- `N`, default 16: number of table entries (power of two, ≥2).
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_vld`  in  1: new conditional command offered.
- `in_cmd`  in  `ob_pkg::cmd_t`: offered command.
- `in_rdy`  out  1: a free entry exists; the command is accepted when `in_vld & in_rdy`.
- `ent_al_vld`  out  N: one-hot allocate strobe to the entries.
- `ent_al_cmd`  out  `ob_pkg::cmd_t`: command broadcast to all entries (equals `in_cmd`).
- `ent_busy_r`  in  N: per-entry busy state (registered).
- `ent_mtr_r`  in  N: per-entry matured state (registered).
- `ent_cmd_r`  in  N × `cmd_t`: per-entry command, opcode already rewritten to Market/Limit.
- `ent_cancel_hit`  in  N: per-entry cancel hit, same cycle.
- `ent_dl_vld`  out  N: one-hot deallocate strobe.
- `out_vld`  out  1: matured command available.
- `out_cmd`  out  `cmd_t`: matured command.
- `out_rdy`  in  1: downstream accepts the command.
- `occ_r`  out  `$clog2(N+1)`: occupied-entry count.
- `full_r`  out  1: `occ_r == N`.

## Operation
- Free vector: `free = ~ent_busy_r`. `in_rdy = |free`. The grant is the lowest-index free entry; `ent_al_vld` is that one-hot ANDed with `in_vld`. The allocation path is purely combinational.
- Matured eligibility: `elig = ent_mtr_r & ~ent_cancel_hit`. A matured entry that is cancelled in the same cycle is never issued.
- Issue load: `ld = |elig & (~out_vld | out_rdy)`.
  - The round-robin arbiter selects from `elig`, starting at pointer `rr_r`.
  - On `ld`: `out_cmd <= ent_cmd_r[sel]`, `out_vld <= 1`, `ent_dl_vld[sel] = 1` in the same cycle, and `rr_r <= sel+1` (mod N).
- Output drain: on `out_vld & out_rdy & ~ld`, clear `out_vld <= 0`. `out_cmd` holds its value while `out_vld & ~out_rdy`.
- Occupancy: `occ_r` next value is `occ_r + alloc - dl - cnc`, where:
  - `alloc = |ent_al_vld`
  - `dl = |ent_dl_vld`
  - `cnc = popcount(ent_cancel_hit & ent_busy_r)`
  - A cancel hitting an entry that is being allocated in the same cycle (idle-entry hit) nets to zero: the entry stays idle, so `alloc` is excluded for that entry.
  - `dl` and `cnc` never target the same entry, because eligibility masks cancels.
- Invariant checked by assertion: `occ_r == popcount(ent_busy_r)` one cycle after any update.
- Reset values: `out_vld=0`, `out_cmd=0`, `rr_r=0`, `occ_r=0`, `full_r=0`. The combinational outputs follow their inputs.

## Timing
- Allocation: an entry accepted at cycle t shows `ent_busy_r=1` at t+1. That entry is not reselected at t, because `ent_al_vld` is a single one-hot.
- Issue latency: `ent_mtr_r` rises at t → `out_vld=1` at t+1 (when the output register is free or draining at t).
- `ent_dl_vld` at t → the entry is idle at t+1. `ent_mtr_r` is low at t+1, so there is no double issue.
- Full: `in_rdy=0`; `in_vld` may stay high. An entry freed by a deallocate at t becomes allocatable at t+1.
- Backpressure: with `out_rdy=0`, matured entries wait in the table (no deallocate) and there is no loss.
- Throughput: back-to-back issue at one command per cycle while `out_rdy=1`.
- Wrap-around: `rr_r` wraps from N−1 to 0. The arbiter search wraps through index N−1 → 0.
- Simultaneous events: allocation, issue and cancel in the same cycle on different entries are all honoured independently.
- Reset mid-operation clears the output register and counters. The entries reset themselves in parallel.

## Structure
- `ob_pkg`: reuse `cmd_t`. Add `CN_N` (default 16) and `cn_ptr_t` (`$clog2(CN_N)` bits).
- Sub-module: `ob_cn_rr_arb` (N-way round-robin arbiter: request vector and pointer in; one-hot grant and encoded index out).
- Use the `libv` register macros for `out_*`, `rr_r` and `occ_r`.

## Test plan
- Reset, then allocate 16 commands back to back with no maturation → `ent_al_vld` one-hot at 0..15, `occ_r=16`, `full_r=1`, `in_rdy=0` on the 17th offer.
- Entries 3, 7 and 12 mature in the same cycle with `out_rdy=1` → issued in order 3, 7, 12 on consecutive cycles. `ent_dl_vld` = bit 3, bit 7, bit 12, each matching its load cycle. `occ_r` decrements by 1 per cycle.
- Entry 5 matured and `out_rdy=0` for 4 cycles → `out_vld` stays high with stable `out_cmd`. Only one deallocate occurs, and the second matured entry (9) waits. It issues the cycle after `out_rdy` rises.
- Entry 4 matured with `ent_cancel_hit[4]=1` in the same cycle → no issue, no deallocate, `occ_r` decrements by 1.
- Table full, entry 0 deallocated at t with `in_vld=1` → `in_rdy=0` at t, then `ent_al_vld` bit 0 at t+1, and `occ_r` returns to 16.
- `rr_r=15`, entries 15 and 0 matured → 15 is issued first, then 0 (wrap).
